// File: rtl/alu_pkg.sv
// Opcode values shared by the ALU datapath and the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SGT = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL, plus SRA when ALU_SRA_EN is defined.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int data_width = 32,
  parameter int sel_width  = 4,
  parameter int sh_width   = $clog2(data_width)
) (
  input  logic [data_width-1:0] value,
  input  logic [sh_width-1:0]   shamt,
  input  logic [sel_width-1:0]  op,
  output logic [data_width-1:0] shifted
);

  always_comb begin
    shifted = '0;
    case (op)
      ALU_SLL: shifted = value << shamt;
      ALU_SRL: shifted = value >> shamt;
`ifdef ALU_SRA_EN
      ALU_SRA: shifted = $signed(value) >>> shamt;
`endif
      default: shifted = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered integer ALU with zero flag; ALU_SRA_EN adds arithmetic right shift (opcode 1010).
// Latency: 1 cycle, fully pipelined, one operation accepted every cycle.
// Backpressure: none; there is no handshake and no stall.
module alu
  import alu_pkg::*;
#(
  parameter int data_width = 32,
  parameter int sel_width  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] operand1,
  input  logic [data_width-1:0] operand2,
  input  logic [sel_width-1:0]  opSel,
  output logic [data_width-1:0] result,
  output logic                  zero
);

  localparam int sh_width = $clog2(data_width);

  logic [data_width-1:0] next_result;
  logic [data_width-1:0] shifted;

  // Only the low log2(data_width) bits of operand1 form the shift amount.
  alu_shifter #(
    .data_width(data_width),
    .sel_width (sel_width),
    .sh_width  (sh_width)
  ) u_shifter (
    .value  (operand2),
    .shamt  (operand1[sh_width-1:0]),
    .op     (opSel),
    .shifted(shifted)
  );

  always_comb begin
    next_result = '0;
    case (opSel)
      ALU_ADD: next_result = operand1 + operand2;
      ALU_SUB: next_result = operand1 - operand2;
      ALU_AND: next_result = operand1 & operand2;
      ALU_OR:  next_result = operand1 | operand2;
      ALU_XOR: next_result = operand1 ^ operand2;
      ALU_NOR: next_result = ~(operand1 | operand2);
      ALU_SLT: next_result = {{(data_width-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      ALU_SGT: next_result = {{(data_width-1){1'b0}}, ($signed(operand1) > $signed(operand2))};
      ALU_SLL: next_result = shifted;
      ALU_SRL: next_result = shifted;
`ifdef ALU_SRA_EN
      ALU_SRA: next_result = shifted;
`endif
      default: next_result = '0;
    endcase
  end

  // zero comes from the same next value as result so the two never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= next_result;
      zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [3:0]  opSel;
  logic [31:0] result;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  alu #(.data_width(32), .sel_width(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .operand1(operand1),
    .operand2(operand2),
    .opSel   (opSel),
    .result  (result),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  // Apply inputs away from the edge, clock once, sample 1 unit after the edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opSel = op; operand1 = a; operand2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opSel = ALU_ADD; operand1 = 32'h0; operand2 = 32'h0;
    #2;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h want=00000000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got=%b want=1", zero); end
    @(negedge clk);
    rst = 1'b0;
    drive(ALU_ADD, 32'h0000000A, 32'h00000005);
    n_cmp++; if (result !== 32'h0000000F) begin n_err++; $display("FAIL first_add got=%h want=0000000F", result); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL first_add_zero got=%b want=0", zero); end
  endtask

  task automatic test_arith_logic();
    logic [3:0]  op [11] = '{ALU_SUB, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
                             4'b1111, ALU_ADD, ALU_ADD, ALU_NOR};
    logic [31:0] a  [11] = '{32'h0000000F, 32'h00000005, 32'h00000000, 32'h0F0F0F0F, 32'h0F0F0F0F,
                             32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'h7FFFFFFF, 32'hFFFFFFFF,
                             32'h0000FFFF};
    logic [31:0] b  [11] = '{32'h00000005, 32'h00000005, 32'h00000001, 32'hF0F0F0F0, 32'hF0F0F0F0,
                             32'hAAAAAAAA, 32'hFFFFFFFF, 32'h87654321, 32'h00000001, 32'h00000001,
                             32'h00FF0000};
    logic [31:0] ex [11] = '{32'h0000000A, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
                             32'h55555555, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000,
                             32'hFF000000};
    for (int i = 0; i < 11; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL arith_logic[%0d] op=%b got=%h want=%h", i, op[i], result, ex[i]); end
      n_cmp++; if (zero !== (ex[i] == 32'h0)) begin n_err++; $display("FAIL arith_logic_zero[%0d] got=%b want=%b", i, zero, (ex[i] == 32'h0)); end
    end
  endtask

  task automatic test_compare();
    logic [3:0]  op [6] = '{ALU_SLT, ALU_SLT, ALU_SGT, ALU_SGT, ALU_SLT, ALU_SGT};
    logic [31:0] a  [6] = '{32'h0000000A, 32'hFFFFFFFF, 32'h0000000F, 32'h00000007, 32'h00000001, 32'h00000001};
    logic [31:0] b  [6] = '{32'h0000000B, 32'h00000001, 32'h0000000A, 32'h00000007, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] ex [6] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000001};
    for (int i = 0; i < 6; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL compare[%0d] got=%h want=%h", i, result, ex[i]); end
      n_cmp++; if (zero !== (ex[i] == 32'h0)) begin n_err++; $display("FAIL compare_zero[%0d] got=%b want=%b", i, zero, (ex[i] == 32'h0)); end
    end
  endtask

  task automatic test_shift();
    logic [31:0] sra_ex;
    logic [3:0]  op [5] = '{ALU_SLL, ALU_SRL, ALU_SRL, ALU_SLL, ALU_SRL};
    logic [31:0] a  [5] = '{32'h00000001, 32'h00000002, 32'h00000024, 32'hFFFFFFE1, 32'h0000001F};
    logic [31:0] b  [5] = '{32'h00000004, 32'h00000010, 32'h00000100, 32'h00000004, 32'h80000000};
    logic [31:0] ex [5] = '{32'h00000008, 32'h00000004, 32'h00000010, 32'h00000008, 32'h00000001};
    for (int i = 0; i < 5; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++; if (result !== ex[i]) begin n_err++; $display("FAIL shift[%0d] got=%h want=%h", i, result, ex[i]); end
    end
`ifdef ALU_SRA_EN
    sra_ex = 32'hF8000000;
`else
    sra_ex = 32'h00000000;
`endif
    drive(ALU_SRA, 32'h00000004, 32'h80000000);
    n_cmp++; if (result !== sra_ex) begin n_err++; $display("FAIL sra got=%h want=%h", result, sra_ex); end
    n_cmp++; if (zero !== (sra_ex == 32'h0)) begin n_err++; $display("FAIL sra_zero got=%b want=%b", zero, (sra_ex == 32'h0)); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op [6] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_AND, ALU_SLT, ALU_OR};
    logic [31:0] a  [6] = '{32'h00000003, 32'h00000003, 32'h00000003, 32'h000000FF, 32'h80000000, 32'h00000000};
    logic [31:0] b  [6] = '{32'h00000004, 32'h00000004, 32'h00000001, 32'h00000F00, 32'h00000000, 32'h00000000};
    logic [31:0] ex [6] = '{32'h00000007, 32'hFFFFFFFF, 32'h00000008, 32'h00000000, 32'h00000001, 32'h00000000};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (result !== ex[i-1]) begin n_err++; $display("FAIL b2b[%0d] got=%h want=%h", i-1, result, ex[i-1]); end
        n_cmp++; if (zero !== (ex[i-1] == 32'h0)) begin n_err++; $display("FAIL b2b_zero[%0d] got=%b want=%b", i-1, zero, (ex[i-1] == 32'h0)); end
      end
      if (i < 6) begin
        opSel = op[i]; operand1 = a[i]; operand2 = b[i];
      end
    end
  endtask

  task automatic test_hold_and_midreset();
    drive(ALU_ADD, 32'h00000001, 32'h00000002);
    // Inputs changing between edges must not reach the outputs.
    opSel = ALU_OR; operand1 = 32'hDEAD0000; operand2 = 32'h0000BEEF;
    #2;
    n_cmp++; if (result !== 32'h00000003) begin n_err++; $display("FAIL hold got=%h want=00000003", result); end
    rst = 1'b1;
    #1;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL midreset_result got=%h want=00000000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL midreset_zero got=%b want=1", zero); end
    @(posedge clk);
    #1;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_held got=%h want=00000000", result); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (result !== 32'hDEADBEEF) begin n_err++; $display("FAIL post_reset got=%h want=DEADBEEF", result); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL post_reset_zero got=%b want=0", zero); end
  endtask

  initial begin
    test_reset();
    test_arith_logic();
    test_compare();
    test_shift();
    test_back_to_back();
    test_hold_and_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
